// File: rtl/xeng_pkg.sv
// rtl/xeng_pkg.sv - shared state type and sizing helpers for the X-engine scheduler
package xeng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_WIN,
    ST_RUN,
    ST_HOLD
  } xeng_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Baselines per window including autocorrelations, as walked by the order generator.
  function automatic int bl_steps(input int n_ants);
    return n_ants * (n_ants / 2 + 1);
  endfunction

endpackage

// File: rtl/xeng_win_ctr.sv
// rtl/xeng_win_ctr.sv - step and window counters with pass-end and first/last decode
module xeng_win_ctr
  import xeng_pkg::*;
#(
  parameter int ACC_LEN  = 1024,
  parameter int BL_STEPS = 144
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  output logic pass_end,
  output logic acc_first,
  output logic acc_last
);

  localparam int SW = clog2(BL_STEPS);
  localparam int WW = clog2(ACC_LEN);
  localparam logic [SW-1:0] STEP_LAST = SW'(BL_STEPS - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(ACC_LEN - 1);

  logic [SW-1:0] step_cnt;
  logic [WW-1:0] win_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      win_idx  <= '0;
    end else if (clear) begin
      step_cnt <= '0;
      win_idx  <= '0;
    end else if (step) begin
      if (pass_end) begin
        step_cnt <= '0;
        win_idx  <= (win_idx == WIN_LAST) ? '0 : win_idx + 1'b1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  assign pass_end  = (step_cnt == STEP_LAST);
  assign acc_first = (win_idx == '0);
  assign acc_last  = (win_idx == WIN_LAST);

endmodule

// File: rtl/xeng_acc_sched.sv
// rtl/xeng_acc_sched.sv - integration scheduler; XENG_ACC_SCHED_STALL_CNT_EN enables the HOLD stall counter
module xeng_acc_sched
  import xeng_pkg::*;
#(
  parameter int N_ANTS  = 16,
  parameter int ACC_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync,
  input  logic        win_valid,
  output logic        win_ready,
  output logic        bl_sync,
  output logic        bl_en,
  output logic        acc_first,
  output logic        acc_last,
  output logic        acc_bank,
  output logic        dump_valid,
  input  logic        dump_ack,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic [15:0] ovf_cnt
);

  localparam int BL_STEPS = bl_steps(N_ANTS);

  xeng_state_e state, state_n;
  logic pass_end, win_first, win_last;
  logic swap, ovf_set;

  xeng_win_ctr #(
    .ACC_LEN (ACC_LEN),
    .BL_STEPS(BL_STEPS)
  ) u_win_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (sync),
    .step     (state == ST_RUN),
    .pass_end (pass_end),
    .acc_first(win_first),
    .acc_last (win_last)
  );

  always_comb begin
    state_n = state;
    swap    = 1'b0;
    ovf_set = 1'b0;
    if (sync) begin
      state_n = ST_ARM;
    end else begin
      case (state)
        ST_IDLE:     state_n = ST_IDLE;
        ST_ARM:      state_n = ST_WAIT_WIN;
        ST_WAIT_WIN: if (win_valid) state_n = ST_RUN;
        ST_RUN: begin
          if (pass_end) begin
            // A finished integration with the other bank still unread must stall.
            if (win_last && dump_valid && !dump_ack) begin
              state_n = ST_HOLD;
              ovf_set = 1'b1;
            end else begin
              swap    = win_last;
              state_n = win_valid ? ST_RUN : ST_WAIT_WIN;
            end
          end
        end
        ST_HOLD: begin
          if (dump_ack) begin
            swap    = 1'b1;
            state_n = ST_WAIT_WIN;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      acc_bank   <= 1'b0;
      dump_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state <= state_n;
      if (sync) begin
        acc_bank   <= 1'b0;
        dump_valid <= 1'b0;
      end else if (swap) begin
        acc_bank   <= ~acc_bank;
        dump_valid <= 1'b1;
      end else if (dump_ack) begin
        dump_valid <= 1'b0;
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign bl_sync   = (state == ST_ARM);
  assign bl_en     = (state == ST_RUN);
  assign win_ready = (state == ST_WAIT_WIN) || ((state == ST_RUN) && pass_end);
  assign acc_first = (state == ST_RUN) && win_first;
  assign acc_last  = (state == ST_RUN) && win_last;

`ifdef XENG_ACC_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        stall_cnt <= '0;
    else if (ovf_clr)                                  stall_cnt <= '0;
    else if (state == ST_HOLD && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end

  assign ovf_cnt = stall_cnt;
`else
  assign ovf_cnt = '0;
`endif

endmodule
